// File: rtl/delay_buffer_if.sv
// Data-path bundle for delay_buffer: the vector going in and its delayed copy.
// The master drives data_in and observes data_out; the slave is the delay line.
interface delay_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output data_in, input data_out);
    modport slave  (input data_in, output data_out);
endinterface

// File: rtl/delay_buffer.sv
// Fixed-latency delay line: data_in reappears on data_out DELAY_CYCLE rising
// edges later. Used to add virtual latency to the bundled APB response
// vector {read data, ready, slverr}; every bit is carried identically.
// DELAY_CYCLE = 0 collapses to a wire and leaves clk/rst_n unused.
// rst_n is active-high despite its name: 1 clears every stage immediately.
module delay_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DELAY_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    delay_buffer_if.slave bus
);

    generate
        if (DELAY_CYCLE == 0) begin : g_bypass
            // Zero latency: the output is the input, no state at all.
            assign bus.data_out = bus.data_in;

            // clk and rst_n have no job in the bypass build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
        end else begin : g_pipe
            // stage_d[k] is what stage k captures on the next edge.
            logic [DELAY_CYCLE-1:0][DATA_WIDTH-1:0] stage_d;
            logic [DELAY_CYCLE-1:0][DATA_WIDTH-1:0] stage_q;

            // Stage 0 loads the incoming word; later stages load their predecessor.
            assign stage_d[0] = bus.data_in;
            for (genvar k = 1; k < DELAY_CYCLE; k++) begin : g_link
                assign stage_d[k] = stage_q[k-1];
            end

            // Shift the whole chain one stage per edge; reset empties it at once.
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    // NOTE: this chain is a bank of flops, not a RAM, so every
                    // stage gets a reset value; in-flight words are dropped and
                    // no X can leak out after reset.
                    stage_q <= '0;
                end else begin
                    // NOTE: non-blocking so every stage samples its predecessor's
                    // old value; blocking would let a word fall through the chain
                    // in a single edge.
                    stage_q <= stage_d;
                end
            end

            // Output comes straight from the last register, no logic after it.
            assign bus.data_out = stage_q[DELAY_CYCLE-1];
        end
    endgenerate

endmodule

// File: tb/tb_delay_buffer.sv
// Self-checking bench for delay_buffer. Four registered instances
// (D=3/W=34, D=1/W=8, D=4/W=8, D=2/W=34) and one bypass instance (D=0/W=8)
// share a clock and reset. The stimulus side pushes the expected output of
// each registered instance into a queue; a monitor pops and compares after
// every rising edge.
module tb_delay_buffer;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    delay_buffer_if #(.DATA_WIDTH(34)) b3 ();
    delay_buffer_if #(.DATA_WIDTH(8))  b1 ();
    delay_buffer_if #(.DATA_WIDTH(8))  b0 ();
    delay_buffer_if #(.DATA_WIDTH(8))  b4 ();
    delay_buffer_if #(.DATA_WIDTH(34)) b2 ();

    delay_buffer #(.DATA_WIDTH(34), .DELAY_CYCLE(3)) u_d3 (.clk(clk), .rst_n(rst), .bus(b3));
    delay_buffer #(.DATA_WIDTH(8),  .DELAY_CYCLE(1)) u_d1 (.clk(clk), .rst_n(rst), .bus(b1));
    delay_buffer #(.DATA_WIDTH(8),  .DELAY_CYCLE(0)) u_d0 (.clk(clk), .rst_n(rst), .bus(b0));
    delay_buffer #(.DATA_WIDTH(8),  .DELAY_CYCLE(4)) u_d4 (.clk(clk), .rst_n(rst), .bus(b4));
    delay_buffer #(.DATA_WIDTH(34), .DELAY_CYCLE(2)) u_d2 (.clk(clk), .rst_n(rst), .bus(b2));

    // Expected outputs, one entry per rising edge after reset release.
    logic [33:0] q3[$];
    logic [7:0]  q1[$];
    logic [7:0]  q4[$];
    logic [33:0] q2[$];

    localparam logic [63:0] NO_EXP = {64{1'bx}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: after k post-reset edges a D-stage line shows the word
    // captured at edge k-D+1, or 0 while k < D. Seeding the queue with D-1
    // zeros followed by each captured word, one pop per edge, encodes that.
    task automatic drive(input logic [33:0] v3, input logic [7:0] v1, input logic [7:0] v0,
                         input logic [7:0] v4, input logic [33:0] v2, input bit rel);
        @(negedge clk);
        b3.data_in = v3;
        b1.data_in = v1;
        b0.data_in = v0;
        b4.data_in = v4;
        b2.data_in = v2;
        if (rel) begin
            #2;
            rst = 1'b0;
            q3.delete(); repeat (2) q3.push_back('0); q3.push_back(v3);
            q1.delete();                              q1.push_back(v1);
            q4.delete(); repeat (3) q4.push_back('0); q4.push_back(v4);
            q2.delete(); repeat (1) q2.push_back('0); q2.push_back(v2);
        end else if (!rst) begin
            q3.push_back(v3);
            q1.push_back(v1);
            q4.push_back(v4);
            q2.push_back(v2);
        end
        #1;
        check("bypass", 64'(b0.data_out), 64'(v0));
    endtask

    function automatic logic [33:0] rnd34();
        logic [33:0] r;
        r = {2'($urandom_range(3, 0)), $urandom()};
        return r;
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(255, 0));
    endfunction

    // Monitor: the delay line presents a new output word after every edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("hold_d3", 64'(b3.data_out), 64'd0);
            check("hold_d1", 64'(b1.data_out), 64'd0);
            check("hold_d4", 64'(b4.data_out), 64'd0);
            check("hold_d2", 64'(b2.data_out), 64'd0);
        end else begin
            check("d3", 64'(b3.data_out), (q3.size() != 0) ? 64'(q3.pop_front()) : NO_EXP);
            check("d1", 64'(b1.data_out), (q1.size() != 0) ? 64'(q1.pop_front()) : NO_EXP);
            check("d4", 64'(b4.data_out), (q4.size() != 0) ? 64'(q4.pop_front()) : NO_EXP);
            check("d2", 64'(b2.data_out), (q2.size() != 0) ? 64'(q2.pop_front()) : NO_EXP);
        end
    end

    initial begin
        logic [33:0] pkt;
        rst        = 1'b0;
        b3.data_in = 34'h3_FFFF_FFFF;
        b1.data_in = 8'h11;
        b0.data_in = 8'h00;
        b4.data_in = 8'h22;
        b2.data_in = 34'h1;

        // Asynchronous reset: outputs clear before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_now_d3", 64'(b3.data_out), 64'd0);
        check("rst_now_d1", 64'(b1.data_out), 64'd0);
        check("rst_now_d4", 64'(b4.data_out), 64'd0);
        check("rst_now_d2", 64'(b2.data_out), 64'd0);

        // Bypass tracks its input combinationally, reset has no effect.
        for (int i = 0; i < 4; i++) begin
            b0.data_in = (i % 2 == 0) ? 8'hFF : 8'h00;
            #0.5;
            check("bypass_toggle", 64'(b0.data_out), (i % 2 == 0) ? 64'hFF : 64'h00);
        end

        // Hold reset with all-ones input on the D=3 line for several edges.
        repeat (3) drive(34'h3_FFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 34'h3_FFFF_FFFF, 1'b0);

        // Release, then incrementing stream on D=3, A5/5A on D=1, and an
        // aligned {data, ready, slverr} response on D=2.
        pkt = {32'hDEADBEEF, 1'b1, 1'b0};
        drive(34'd1, 8'hA5, 8'h00, rnd8(), pkt, 1'b1);
        drive(34'd2, 8'h5A, 8'hFF, rnd8(), 34'd0, 1'b0);
        for (int i = 3; i <= 20; i++) begin
            drive(34'(i), rnd8(), rnd8(), rnd8(), rnd34(), 1'b0);
        end

        // Randomized traffic.
        repeat (30) drive(rnd34(), rnd8(), rnd8(), rnd8(), rnd34(), 1'b0);

        // Mid-stream reset pulse strictly between two edges.
        drive(34'h1_2345_6789, 8'h9C, 8'h3C, 8'h7E, 34'h2_AAAA_5555, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("pulse_d3", 64'(b3.data_out), 64'd0);
        check("pulse_d1", 64'(b1.data_out), 64'd0);
        check("pulse_d4", 64'(b4.data_out), 64'd0);
        check("pulse_d2", 64'(b2.data_out), 64'd0);
        drive(34'h0_0000_00C3, 8'hC3, 8'hC3, 8'hC3, 34'h3_0000_00C3, 1'b1);
        repeat (20) drive(rnd34(), rnd8(), rnd8(), rnd8(), rnd34(), 1'b0);

        // Drain the longest line.
        repeat (5) drive(34'd0, 8'd0, 8'd0, 8'd0, 34'd0, 1'b0);
        @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_buffer.md
Name: delay_buffer

Overview:
- Fixed-latency pipeline delay line: every bit of data_in reaches data_out exactly DELAY_CYCLE clock edges later.
- Used inside the APB slave wrapper to add virtual bus latency to the bundled {read data, ready, slverr} response vector.
- Pure data path, no handshake; every bit is treated identically.

Parameters:
- DATA_WIDTH, default 8: width of data_in/data_out in bits; legal range 1 or more.
- DELAY_CYCLE, default 1: number of register stages (clock cycles of latency); legal range 0 or more. 0 = combinational bypass.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1), despite the codebase name.
- data_in  input  DATA_WIDTH  vector to delay.
- data_out  output  DATA_WIDTH  data_in delayed by DELAY_CYCLE cycles.

Behaviour:
- Structure: chain of DELAY_CYCLE registers, stage[0] .. stage[DELAY_CYCLE-1], each DATA_WIDTH bits wide.
  - stage[0] <= data_in.
  - stage[k] <= stage[k-1].
  - data_out = stage[DELAY_CYCLE-1], driven directly from the register with no output logic.
- Latency:
  - A value present on data_in at rising edge n is visible on data_out after rising edge n+DELAY_CYCLE-1 and holds until edge n+DELAY_CYCLE.
  - Example: DELAY_CYCLE=1 is a single flop; data_out equals data_in from the previous edge.
- DELAY_CYCLE = 0:
  - data_out = data_in, combinational.
  - No registers are instantiated; clk and rst_n are unused.
- Throughput: one new word accepted every cycle. There is no enable, no stall and no bubble handling.
- Reset (rst_n = 1):
  - Asynchronously clears all stages to 0, so data_out = 0 immediately without waiting for a clock edge.
  - Stages stay 0 while reset is held.
- Reset mid-operation: all in-flight words are discarded, not flushed out.
- After release (1->0):
  - The first capture happens at the first rising edge with rst_n = 0.
  - data_out stays 0 until DELAY_CYCLE such edges have occurred, then follows the delayed input.
- Simultaneous reset and clock edge: reset wins and all stages are 0.
- Width rules:
  - Bit-exact transfer, no sign extension, no arithmetic.
  - Any DATA_WIDTH is legal, including 1 and widths above 64.
- No X propagation from reset: every stage has a defined reset value of 0.
- Implementation constraints:
  - Use a generate loop over the stage count.
  - Use a single always block with asynchronous-reset sensitivity on the active-high edge of rst_n.
  - No memory inference is required.

Test Plan:
- Reset value: DATA_WIDTH=34, DELAY_CYCLE=3; assert rst_n=1 with data_in=34'h3_FFFF_FFFF -> data_out=0 immediately and on every clock while reset is held.
- Latency: DELAY_CYCLE=3, release reset, drive incrementing data_in 1,2,3,... one per edge -> data_out 0 for the first 2 edges after release. The value 1 appears after the 3rd edge, then 2,3,... consecutively with no gaps.
- Single flop: DELAY_CYCLE=1, data_in=8'hA5 at edge n, then 8'h5A at edge n+1 -> data_out=A5 after edge n, 5A after edge n+1.
- Bypass: DELAY_CYCLE=0, toggle data_in between 8'h00 and 8'hFF without any clock -> data_out tracks combinationally; rst_n=1 has no effect.
- Mid-stream reset: DELAY_CYCLE=4, stream nonzero words, pulse rst_n high for half a clock period between edges -> data_out drops to 0 asynchronously. After release, the pre-reset words never appear, and the first post-reset word emerges exactly 4 edges after its capture.
- Bit independence: DATA_WIDTH=34 with the vector packed as {data[31:0], ready, slverr}, DELAY_CYCLE=2 -> ready=1 with data=32'hDEADBEEF and slverr=0 reappear together, aligned, exactly 2 cycles later.
